// File: rtl/vb_io_pkg.sv
// -----------------------------------------------------------------------------
// vb_io_pkg
// Shared definitions for the keypad receive path:
//   - rx_state_e : capture FSM states (IDLE / SHIFT / DONE)
//   - KEY_*      : bit positions of each key inside a frame / the keys register
//   - NBITS_DEF  : default number of key bits carried per frame
// -----------------------------------------------------------------------------
package vb_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } rx_state_e;

  localparam int KEY_START  = 7;
  localparam int KEY_SELECT = 6;
  localparam int KEY_B      = 5;
  localparam int KEY_A      = 4;
  localparam int KEY_DOWN   = 3;
  localparam int KEY_UP     = 2;
  localparam int KEY_LEFT   = 1;
  localparam int KEY_RIGHT  = 0;

  localparam int NBITS_DEF  = 8;

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Accepts one raw key frame per strobe and only commits it to the visible key
// state once the same frame has been seen DEBOUNCE times in a row.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   raw_i        in   NBITS raw frame, valid while strobe_i is high
//   strobe_i     in   one-cycle strobe marking a complete raw frame
//   keys_o       out  NBITS debounced key state (1 = pressed)
//   keys_valid_o out  set once the first debounced frame has been committed
//   press_irq_o  out  one-cycle pulse when any key bit goes 0->1
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int NBITS    = 8,
  parameter int DEBOUNCE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBITS-1:0] raw_i,
  input  logic             strobe_i,
  output logic [NBITS-1:0] keys_o,
  output logic             keys_valid_o,
  output logic             press_irq_o
);

  localparam logic [3:0] DB = 4'(DEBOUNCE);

  logic [NBITS-1:0] cand_q, cand_d;
  logic [3:0]       dcnt_q, dcnt_d;
  logic [NBITS-1:0] keys_q, keys_d;
  logic             valid_q, valid_d;
  logic             irq_q, irq_d;

  always_comb begin
    cand_d  = cand_q;
    dcnt_d  = dcnt_q;
    keys_d  = keys_q;
    valid_d = valid_q;
    irq_d   = 1'b0;
    if (strobe_i) begin
      if (raw_i == cand_q) begin
        dcnt_d = (dcnt_q >= DB) ? DB : dcnt_q + 4'd1;
      end else begin
        cand_d = raw_i;
        dcnt_d = 4'd1;
      end
      // Decision uses the post-update counter/candidate so DEBOUNCE=1
      // commits on the very first frame of a new value.
      if ((dcnt_d == DB) && (cand_d != keys_q)) begin
        keys_d  = cand_d;
        valid_d = 1'b1;
        irq_d   = |(cand_d & ~keys_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q  <= '0;
      dcnt_q  <= '0;
      keys_q  <= '0;
      valid_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      cand_q  <= cand_d;
      dcnt_q  <= dcnt_d;
      keys_q  <= keys_d;
      valid_q <= valid_d;
      irq_q   <= irq_d;
    end
  end

  assign keys_o       = keys_q;
  assign keys_valid_o = valid_q;
  assign press_irq_o  = irq_q;

endmodule

// File: rtl/key_deserializer.sv
// -----------------------------------------------------------------------------
// key_deserializer
// Receives the serial keypad link: after each csync, samples skey on every
// pvalid strobe (MSB first) to build an NBITS raw frame, then hands complete
// frames to the debouncer which drives the joypad-visible key state.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset (discards any partial frame)
//   csync      in   frame sync strobe; (re)starts a capture
//   pvalid     in   bit-slot strobe; one sample per high cycle
//   skey       in   serial key data
//   keys       out  NBITS debounced key state (1 = pressed)
//   keys_valid out  high once a debounced frame has been accepted
//   frame_done out  one-cycle pulse per complete raw frame
//   press_irq  out  one-cycle pulse when any key goes released->pressed
// -----------------------------------------------------------------------------
module key_deserializer
  import vb_io_pkg::*;
#(
  parameter int NBITS    = NBITS_DEF,
  parameter int DEBOUNCE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             csync,
  input  logic             pvalid,
  input  logic             skey,
  output logic [NBITS-1:0] keys,
  output logic             keys_valid,
  output logic             frame_done,
  output logic             press_irq
);

  localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(NBITS - 1);

  rx_state_e        state_q, state_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic [NBITS-1:0] shreg_q, shreg_d;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    unique case (state_q)
      ST_IDLE: begin
        if (csync) begin
          state_d  = ST_SHIFT;
          bitcnt_d = '0;
        end
      end
      ST_SHIFT: begin
        // csync beats pvalid: a sync mid-frame throws the partial frame away
        // and restarts without taking a sample in the sync cycle.
        if (csync) begin
          bitcnt_d = '0;
        end else if (pvalid) begin
          shreg_d = {shreg_q[NBITS-2:0], skey};
          if (bitcnt_q == LAST_BIT) begin
            state_d  = ST_DONE;
            bitcnt_d = '0;
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        // A sync landing on the DONE cycle starts the next capture directly.
        state_d  = csync ? ST_SHIFT : ST_IDLE;
        bitcnt_d = '0;
      end
      default: begin
        state_d  = ST_IDLE;
        bitcnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  // Shift data needs no reset: it is only consumed after a full capture.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  assign frame_done = (state_q == ST_DONE);

  key_debounce #(
    .NBITS    (NBITS),
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk          (clk),
    .rst          (rst),
    .raw_i        (shreg_q),
    .strobe_i     (frame_done),
    .keys_o       (keys),
    .keys_valid_o (keys_valid),
    .press_irq_o  (press_irq)
  );

endmodule
